// File: rtl/fsm_pkg.sv
// Shared definitions for the serial framing and sequence-detector blocks:
// state encodings, the default sync pattern and a small sizing helper.
package fsm_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        PRE  = 2'b01,
        PAY  = 2'b10,
        PAR  = 2'b11
    } state_t;

    localparam logic [3:0] DEFAULT_PREAMBLE = 4'b1011;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/tx_shift_reg.sv
// Payload holding register for the frame transmitter. Loads a word, shifts it
// out MSB first, and keeps the even parity of the loaded word. The parity is
// captured at load time because the word itself is consumed by shifting.
module tx_shift_reg
#(
    parameter int DATA_W = 8
)
(
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              shift,
    input  logic [DATA_W-1:0] data_in,
    output logic              msb,
    output logic              parity
);

    logic [DATA_W-1:0] sr;

    // Load takes priority over shift; zeros fill in behind the outgoing bits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr     <= '0;
            parity <= 1'b0;
        end else if (load) begin
            sr     <= data_in;
            parity <= ^data_in;
        end else if (shift) begin
            sr <= sr << 1;
        end
    end

    assign msb = sr[DATA_W-1];

endmodule

// File: rtl/seq_frame_tx.sv
// Serial frame transmitter: preamble, payload MSB first, optional even-parity
// bit. One serial bit advances per bit_tick; tx_bit, tx_active and frame_done
// are registered, data_ready decodes the IDLE state.
module seq_frame_tx
    import fsm_pkg::*;
#(
    parameter int               DATA_W    = 8,
    parameter int               PRE_W     = 4,
    parameter logic [PRE_W-1:0] PREAMBLE  = PRE_W'(DEFAULT_PREAMBLE),
    parameter int               PARITY_EN = 1
)
(
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] data_in,
    input  logic              data_valid,
    output logic              data_ready,
    input  logic              bit_tick,
    output logic              tx_bit,
    output logic              tx_active,
    output logic              frame_done
);

    // The counter only ever holds "bits remaining in the current field".
    localparam int CNT_MAX = max_int(PRE_W, DATA_W);
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CNT_W-1:0] PRE_LAST = CNT_W'(PRE_W - 1);
    localparam logic [CNT_W-1:0] PAY_LAST = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             sr_load;
    logic             sr_shift;
    logic             sr_msb;
    logic             sr_parity;
    logic             pre_next;

    tx_shift_reg #(
        .DATA_W (DATA_W)
    ) u_shift (
        .clk     (clk),
        .rst     (rst),
        .load    (sr_load),
        .shift   (sr_shift),
        .data_in (data_in),
        .msb     (sr_msb),
        .parity  (sr_parity)
    );

    assign data_ready = (state == IDLE);

    // Load on acceptance; shift whenever a payload bit has just been moved onto tx_bit.
    always_comb begin
        sr_load  = (state == IDLE) && data_valid;
        sr_shift = bit_tick && (((state == PRE) && (cnt == '0)) ||
                                ((state == PAY) && (cnt != '0)));
    end

    // Preamble bit that follows the one currently on the line.
    always_comb begin
        pre_next = 1'b0;
        for (int i = 0; i < PRE_W; i++) begin
            if (CNT_W'(i) == (cnt - CNT_ONE)) begin
                pre_next = PREAMBLE[i];
            end
        end
    end

    // Frame sequencing with registered serial outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            tx_bit     <= 1'b0;
            tx_active  <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (data_valid) begin
                        state     <= PRE;
                        cnt       <= PRE_LAST;
                        tx_bit    <= PREAMBLE[PRE_W-1];
                        tx_active <= 1'b1;
                    end else begin
                        tx_bit    <= 1'b0;
                        tx_active <= 1'b0;
                    end
                end
                PRE: begin
                    if (bit_tick) begin
                        if (cnt == '0) begin
                            state  <= PAY;
                            cnt    <= PAY_LAST;
                            tx_bit <= sr_msb;
                        end else begin
                            cnt    <= cnt - CNT_ONE;
                            tx_bit <= pre_next;
                        end
                    end
                end
                PAY: begin
                    if (bit_tick) begin
                        if (cnt != '0) begin
                            cnt    <= cnt - CNT_ONE;
                            tx_bit <= sr_msb;
                        end else if (PARITY_EN != 0) begin
                            state  <= PAR;
                            tx_bit <= sr_parity;
                        end else begin
                            state      <= IDLE;
                            cnt        <= '0;
                            tx_bit     <= 1'b0;
                            tx_active  <= 1'b0;
                            frame_done <= 1'b1;
                        end
                    end
                end
                PAR: begin
                    if (bit_tick) begin
                        state      <= IDLE;
                        cnt        <= '0;
                        tx_bit     <= 1'b0;
                        tx_active  <= 1'b0;
                        frame_done <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    cnt       <= '0;
                    tx_bit    <= 1'b0;
                    tx_active <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_frame_tx.sv
// Self-checking bench for seq_frame_tx: vector table, directed multi-cycle
// sequences and randomized traffic against a queue-based frame model.
module tb_seq_frame_tx;

    localparam logic [3:0] PRE_BITS = 4'b1011;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] data_in = 8'h00;
    logic       data_valid = 1'b0;
    logic       bit_tick = 1'b0;
    logic       data_ready;
    logic       tx_bit;
    logic       tx_active;
    logic       frame_done;

    logic [3:0] d2 = 4'h0;
    logic       v2 = 1'b0;
    logic       t2 = 1'b0;
    logic       ready2;
    logic       bit2;
    logic       active2;
    logic       done2;

    int n_compared = 0;
    int n_mismatched = 0;

    bit m_active = 1'b0;
    bit m_bit = 1'b0;
    bit m_done = 1'b0;
    bit m_q[$];

    typedef struct {
        logic       v;
        logic [7:0] d;
        logic       t;
        logic       eb;
        logic       ea;
        logic       ed;
        logic       er;
    } vec_t;

    vec_t vecs[$];

    seq_frame_tx dut (
        .clk        (clk),
        .rst        (rst),
        .data_in    (data_in),
        .data_valid (data_valid),
        .data_ready (data_ready),
        .bit_tick   (bit_tick),
        .tx_bit     (tx_bit),
        .tx_active  (tx_active),
        .frame_done (frame_done)
    );

    seq_frame_tx #(
        .DATA_W    (4),
        .PRE_W     (2),
        .PREAMBLE  (2'b10),
        .PARITY_EN (0)
    ) dut2 (
        .clk        (clk),
        .rst        (rst),
        .data_in    (d2),
        .data_valid (v2),
        .data_ready (ready2),
        .bit_tick   (t2),
        .tx_bit     (bit2),
        .tx_active  (active2),
        .frame_done (done2)
    );

    always #5 clk = ~clk;

    function automatic void checkVal(input string name, input logic [31:0] actual,
                                     input logic [31:0] expected);
        n_compared++;
        if (actual !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endfunction

    // Frame model: a frame is the list of its bits; each tick pops the next one.
    function automatic void modelStep();
        if (rst) begin
            m_active = 1'b0;
            m_bit    = 1'b0;
            m_done   = 1'b0;
            m_q.delete();
        end else if (!m_active) begin
            m_done = 1'b0;
            m_bit  = 1'b0;
            if (data_valid) begin
                m_q.delete();
                for (int i = 3; i >= 0; i--) m_q.push_back(PRE_BITS[i]);
                for (int i = 7; i >= 0; i--) m_q.push_back(data_in[i]);
                m_q.push_back(^data_in);
                m_bit    = m_q.pop_front();
                m_active = 1'b1;
            end
        end else begin
            m_done = 1'b0;
            if (bit_tick) begin
                if (m_q.size() == 0) begin
                    m_active = 1'b0;
                    m_bit    = 1'b0;
                    m_done   = 1'b1;
                end else begin
                    m_bit = m_q.pop_front();
                end
            end
        end
    endfunction

    function automatic void checkOutput(input string tag);
        checkVal({tag, ".tx_bit"},     tx_bit,     m_bit);
        checkVal({tag, ".tx_active"},  tx_active,  m_active);
        checkVal({tag, ".frame_done"}, frame_done, m_done);
        checkVal({tag, ".data_ready"}, data_ready, !m_active);
    endfunction

    task automatic applyStimulus(input logic v, input logic [7:0] d, input logic t,
                                 input string tag);
        data_valid = v;
        data_in    = d;
        bit_tick   = t;
        @(posedge clk);
        modelStep();
        #1;
        checkOutput(tag);
    endtask

    function automatic void addVec(input logic v, input logic [7:0] d, input logic t,
                                   input logic eb, input logic ea, input logic ed,
                                   input logic er);
        vec_t x;
        x.v = v; x.d = d; x.t = t; x.eb = eb; x.ea = ea; x.ed = ed; x.er = er;
        vecs.push_back(x);
    endfunction

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [12:0] exp07;
        logic [5:0]  exp2;
        logic [3:0]  hist;
        int          active_cnt;
        int          nbits;
        int          hits;
        int          done_cnt;
        bit          done_seen;

        // Frame for 8'hA5 with a tick every cycle; mid-frame offers are ignored.
        addVec(1, 8'hA5, 1, 1, 1, 0, 0);
        addVec(0, 8'h00, 1, 0, 1, 0, 0);
        addVec(0, 8'h00, 1, 1, 1, 0, 0);
        addVec(1, 8'h00, 1, 1, 1, 0, 0);
        addVec(0, 8'h00, 1, 1, 1, 0, 0);
        addVec(0, 8'h00, 1, 0, 1, 0, 0);
        addVec(0, 8'h00, 1, 1, 1, 0, 0);
        addVec(1, 8'hFF, 1, 0, 1, 0, 0);
        addVec(0, 8'h00, 1, 0, 1, 0, 0);
        addVec(0, 8'h00, 1, 1, 1, 0, 0);
        addVec(0, 8'h00, 1, 0, 1, 0, 0);
        addVec(0, 8'h00, 1, 1, 1, 0, 0);
        addVec(0, 8'h00, 1, 0, 1, 0, 0);
        addVec(0, 8'h00, 1, 0, 0, 1, 1);
        addVec(0, 8'h00, 1, 0, 0, 0, 1);

        // Reset state.
        rst = 1'b1;
        applyStimulus(0, 8'h00, 1, "rst");
        applyStimulus(1, 8'h5A, 1, "rst");
        checkVal("rst.tx_bit",      tx_bit,     0);
        checkVal("rst.tx_active",   tx_active,  0);
        checkVal("rst.frame_done",  frame_done, 0);
        checkVal("rst.data_ready",  data_ready, 1);
        checkVal("rst.dut2_ready",  ready2,     1);
        checkVal("rst.dut2_active", active2,    0);
        rst = 1'b0;
        applyStimulus(0, 8'h00, 0, "idle");

        // Vector table.
        foreach (vecs[k]) begin
            applyStimulus(vecs[k].v, vecs[k].d, vecs[k].t, "vec");
            checkVal($sformatf("vec%0d.tx_bit", k),     tx_bit,     vecs[k].eb);
            checkVal($sformatf("vec%0d.tx_active", k),  tx_active,  vecs[k].ea);
            checkVal($sformatf("vec%0d.frame_done", k), frame_done, vecs[k].ed);
            checkVal($sformatf("vec%0d.data_ready", k), data_ready, vecs[k].er);
        end

        // Slow ticks: every bit of 8'h07 held for three cycles.
        exp07      = 13'b1011_0000_0111_1;
        active_cnt = 0;
        done_seen  = 1'b0;
        applyStimulus(1, 8'h07, 0, "slow");
        if (tx_active) begin
            checkVal("slow.bit", tx_bit, exp07[12]);
            active_cnt++;
        end
        for (int j = 1; j < 200 && !done_seen; j++) begin
            applyStimulus(0, 8'hFF, (j % 3 == 0), "slow");
            if (tx_active) begin
                if (active_cnt < 39) checkVal("slow.bit", tx_bit, exp07[12 - active_cnt / 3]);
                active_cnt++;
            end
            if (frame_done) done_seen = 1'b1;
        end
        checkVal("slow.done_seen", done_seen, 1);
        checkVal("slow.active_cycles", active_cnt, 39);

        // Loopback into a 1011 detector with an all-zero payload.
        hist  = 4'h0;
        nbits = 0;
        hits  = 0;
        done_seen = 1'b0;
        applyStimulus(1, 8'h00, 1, "loop");
        for (int j = 0; j < 40 && !done_seen; j++) begin
            if (tx_active) begin
                hist = {hist[2:0], tx_bit};
                nbits++;
                if (nbits >= 4 && hist == 4'b1011) hits++;
            end
            applyStimulus(0, 8'h00, 1, "loop");
            if (frame_done) done_seen = 1'b1;
        end
        checkVal("loop.bits", nbits, 13);
        checkVal("loop.hits", hits, 1);

        // Back-to-back frames with data_valid held high.
        done_seen = 1'b0;
        applyStimulus(1, 8'h3C, 1, "b2b");
        for (int j = 0; j < 40 && !done_seen; j++) begin
            applyStimulus(1, 8'hC3, 1, "b2b");
            if (frame_done) done_seen = 1'b1;
        end
        checkVal("b2b.done_seen", done_seen, 1);
        checkVal("b2b.gap_ready", data_ready, 1);
        applyStimulus(1, 8'hC3, 1, "b2b");
        checkVal("b2b.second_active", tx_active, 1);
        checkVal("b2b.second_first_bit", tx_bit, 1);
        for (int j = 0; j < 20; j++) applyStimulus(0, 8'h00, 1, "b2b");

        // Reset mid-payload of 8'hFF, then a clean frame.
        applyStimulus(1, 8'hFF, 1, "abort");
        for (int j = 0; j < 7; j++) applyStimulus(0, 8'h00, 1, "abort");
        checkVal("abort.pre_active", tx_active, 1);
        #1 rst = 1'b1;
        #1;
        checkVal("abort.tx_active",  tx_active,  0);
        checkVal("abort.tx_bit",     tx_bit,     0);
        checkVal("abort.frame_done", frame_done, 0);
        checkVal("abort.data_ready", data_ready, 1);
        applyStimulus(0, 8'h00, 1, "abort");
        rst = 1'b0;
        done_cnt = 0;
        for (int j = 0; j < 16; j++) begin
            applyStimulus(0, 8'h00, 1, "abort_idle");
            if (frame_done) done_cnt++;
        end
        checkVal("abort.no_done", done_cnt, 0);
        applyStimulus(1, 8'h5A, 1, "after");
        for (int j = 0; j < 16; j++) applyStimulus(0, 8'h00, 1, "after");

        // Small configuration without parity.
        exp2 = 6'b101001;
        v2 = 1'b1; d2 = 4'h9; t2 = 1'b1;
        applyStimulus(0, 8'h00, 1, "cfg2");
        checkVal("cfg2.active0", active2, 1);
        checkVal("cfg2.bit0", bit2, exp2[5]);
        v2 = 1'b0; d2 = 4'h6;
        for (int k = 1; k < 6; k++) begin
            applyStimulus(0, 8'h00, 1, "cfg2");
            checkVal($sformatf("cfg2.bit%0d", k), bit2, exp2[5 - k]);
            checkVal($sformatf("cfg2.active%0d", k), active2, 1);
        end
        applyStimulus(0, 8'h00, 1, "cfg2");
        checkVal("cfg2.done", done2, 1);
        checkVal("cfg2.done_active", active2, 0);
        checkVal("cfg2.done_bit", bit2, 0);
        checkVal("cfg2.done_ready", ready2, 1);
        applyStimulus(0, 8'h00, 1, "cfg2");
        checkVal("cfg2.done_pulse", done2, 0);

        // Randomized traffic with occasional resets.
        for (int j = 0; j < 600; j++) begin
            rst = ($urandom_range(0, 99) == 0);
            applyStimulus(($urandom_range(0, 3) == 0), 8'($urandom),
                          ($urandom_range(0, 2) != 0), "rand");
        end
        rst = 1'b0;
        for (int j = 0; j < 20; j++) applyStimulus(0, 8'h00, 1, "drain");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

// File: doc/seq_frame_tx.md
SEQ_FRAME_TX -- requirements
Module: seq_frame_tx

Interface
REQ-001 Parameter DATA_W, default 8, payload width in bits (>=1).
REQ-002 Parameter PRE_W, default 4, preamble width in bits (>=1).
REQ-003 Parameter PREAMBLE, default 4'b1011, sync pattern, sent MSB first.
REQ-004 Parameter PARITY_EN, default 1; 1 = append even-parity bit, 0 = no parity bit.
REQ-005 clk  in  1  clock; all state changes on the rising edge.
REQ-006 rst  in  1  reset, asynchronous, active-high.
REQ-007 data_in  in  DATA_W  payload word, sampled only on acceptance.
REQ-008 data_valid  in  1  payload offered.
REQ-009 data_ready  out  1  block can accept a payload.
REQ-010 bit_tick  in  1  bit-rate strobe; one serial bit advances per high cycle.
REQ-011 tx_bit  out  1  registered serial output.
REQ-012 tx_active  out  1  high while a frame bit is on tx_bit.
REQ-013 frame_done  out  1  one-cycle pulse after the last frame bit.

Function
REQ-014 The FSM SHALL have four states: IDLE, PRE, PAY and PAR.
REQ-015 In IDLE: data_ready=1, tx_active=0, tx_bit=0; all other states: data_ready=0.
REQ-016 Acceptance SHALL occur when data_valid && data_ready on a rising edge; data_in is latched into the shift register, the bit counter loads PRE_W-1, and the FSM goes to PRE.
REQ-017 On the cycle after acceptance, tx_active=1 and tx_bit=PREAMBLE[PRE_W-1]; bit_tick in the acceptance cycle SHALL be ignored.
REQ-018 Each bit SHALL hold on tx_bit until a cycle with bit_tick=1; that edge presents the next bit; bit_tick=0 cycles SHALL change nothing.
REQ-019 PRE SHALL send PREAMBLE MSB→LSB; after its last tick, go to PAY with the counter at DATA_W-1.
REQ-020 PAY SHALL send the latched payload MSB→LSB; after its last tick, go to PAR if PARITY_EN=1, else finish.
REQ-021 PAR SHALL send the XOR of all latched payload bits (even parity) for one bit period.
REQ-022 Finish: on the tick ending the final bit, go to IDLE; the next cycle has frame_done=1 for exactly one cycle with tx_active=0 and tx_bit=0.
REQ-023 Frame length SHALL be PRE_W+DATA_W+PARITY_EN bit periods; the counter never wraps mid-field.
REQ-024 data_valid and data_in changes while not in IDLE SHALL be ignored; no queuing.
REQ-025 data_ready SHALL rise in the frame_done cycle, so back-to-back acceptance is possible with one idle cycle between frames.
REQ-026 Illegal state encodings SHALL recover to IDLE on the next edge.

Reset
REQ-027 While rst=1: state=IDLE, counter=0, shift register=0, tx_bit=0, tx_active=0, frame_done=0, data_ready=1 (combinational from IDLE).
REQ-028 rst asserted mid-frame SHALL abort the frame immediately with no frame_done; the aborted payload is never resent.
REQ-029 All outputs are registered except data_ready, which decodes the state.

Structure
REQ-030 State encodings (IDLE=2'b00, PRE=2'b01, PAY=2'b10, PAR=2'b11) and the default PREAMBLE constant SHALL live in the shared package fsm_pkg, also used by the sequence detectors.
REQ-031 One sub-module, tx_shift_reg, SHALL hold the DATA_W-bit load/shift register with a parity output; the FSM and counter stay in seq_frame_tx.

Verification
REQ-032 Default parameters, data_in=8'hA5, bit_tick always 1 -> tx_bit = 1,0,1,1, 1,0,1,0,0,1,0,1, 0 over 13 cycles, then frame_done pulse, tx_active=0.
REQ-033 data_in=8'h07, bit_tick high every 3rd cycle -> each bit held for exactly 3 cycles; parity bit=1; frame_done after 39 cycles of tx_active.
REQ-034 Loopback: tx_bit sampled on ticks into the 1011 detector -> detector fires once at preamble end and never during payload 8'h00.
REQ-035 data_valid held high with 8'h3C then 8'hC3 -> two complete frames separated by one idle cycle; data_in changes mid-frame do not alter tx_bit.
REQ-036 rst pulsed during the payload bit 4 of 8'hFF -> outputs go idle within the same cycle, no frame_done; next accepted frame is correct from its first bit.
REQ-037 PARITY_EN=0, PRE_W=2, PREAMBLE=2'b10, DATA_W=4, data_in=4'h9 -> tx_bit = 1,0,1,0,0,1, then frame_done.
